// File: rtl/cpu_ctrl_seq_pkg.sv
// Shared definitions for the cpu_ctrl_seq sequencer: opcodes, instruction layout, FSM states.
package cpu_ctrl_seq_pkg;

  typedef enum logic [3:0] {
    OpAnd   = 4'd0,
    OpOr    = 4'd1,
    OpAdd   = 4'd2,
    OpSub   = 4'd3,
    OpCmp   = 4'd4,
    OpAddi  = 4'd5,
    OpSubi  = 4'd6,
    OpCmpi  = 4'd7,
    OpLoad  = 4'd8,
    OpStore = 4'd9,
    OpJmp   = 4'd10,
    OpJmpr  = 4'd11,
    OpJnz   = 4'd12,
    OpLi    = 4'd13,
    OpIll14 = 4'd14,
    OpIll15 = 4'd15
  } opcode_e;

  // Packed layout gives the field positions: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
  typedef struct packed {
    opcode_e    op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
  } instr_t;

  typedef enum logic [2:0] {
    StFetch = 3'd0,
    StExec  = 3'd1,
    StMem   = 3'd2,
    StWb    = 3'd3,
    StHalt  = 3'd4
  } state_e;

  function automatic logic sets_zf(opcode_e op);
    return op inside {OpAnd, OpOr, OpAdd, OpSub, OpCmp, OpAddi, OpSubi, OpCmpi};
  endfunction

  function automatic logic writes_rd(opcode_e op);
    return op inside {OpAnd, OpOr, OpAdd, OpSub, OpAddi, OpSubi, OpLi, OpLoad};
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous write port.
module cpu_ctrl_seq_regfile #(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_b,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata
);

  logic [7:0] regs_q [4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= REG_INIT;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Fetch/exec/mem/writeback sequencer and decoder driving an external ALU.
// Optional macro CPU_CTRL_ILLOP_HALT_EN: opcodes 14/15 halt the core instead of acting as NOP.
module cpu_ctrl_seq
  import cpu_ctrl_seq_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [7:0]  dmem_addr,
  output logic [7:0]  dmem_wdata,
  input  logic        dmem_ack,
  input  logic [7:0]  dmem_rdata,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_in0,
  output logic [7:0]  alu_in1,
  input  logic [7:0]  alu_out,
  input  logic        alu_zf,
  output logic [7:0]  pc,
  output logic        halted
);

  state_e     state_q, state_d;
  instr_t     fetch_ins;
  opcode_e    op_q;
  logic [1:0] rd_q;
  logic [7:0] pc_q, res_q, next_pc;
  logic       zflag_q;
  logic [3:0] alu_op_q;
  logic [7:0] alu_in0_q, alu_in1_q, in0_d, in1_d;
  logic [7:0] dmem_addr_q, dmem_wdata_q;
  logic       dmem_we_q;
  logic [7:0] rs_val, rd_val;
  logic       is_mem_op;

  assign fetch_ins = instr_t'(imem_rdata);
  assign is_mem_op = op_q inside {OpLoad, OpStore};

  // Port b reads rd from the incoming word during fetch, from the latched IR afterwards.
  cpu_ctrl_seq_regfile #(
    .REG_INIT (REG_INIT)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (fetch_ins.rs),
    .rdata_a (rs_val),
    .raddr_b ((state_q == StFetch) ? fetch_ins.rd : rd_q),
    .rdata_b (rd_val),
    .we      ((state_q == StWb) && writes_rd(op_q)),
    .waddr   (rd_q),
    .wdata   (res_q)
  );

  always_comb begin
    in0_d = fetch_ins.imm;
    in1_d = 8'h00;
    unique case (fetch_ins.op)
      OpAnd, OpOr, OpAdd, OpSub, OpCmp: begin
        in0_d = rs_val;
        in1_d = rd_val;
      end
      OpAddi, OpSubi, OpCmpi:  in1_d = rd_val;
      OpLoad, OpStore, OpJmpr: in1_d = rs_val;
      default: ;
    endcase
  end

  always_comb begin
    next_pc = pc_q + 8'd1;
    unique case (op_q)
      OpJmp, OpJmpr: next_pc = res_q;
      OpJnz:         next_pc = zflag_q ? res_q : pc_q + 8'd1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (imem_ack) state_d = StExec;
      StExec: begin
        if (is_mem_op) state_d = StMem;
`ifdef CPU_CTRL_ILLOP_HALT_EN
        else if (op_q inside {OpIll14, OpIll15}) state_d = StHalt;
`endif
        else state_d = StWb;
      end
      StMem:   if (dmem_ack) state_d = StWb;
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q         <= OpAnd;
      rd_q         <= 2'd0;
      pc_q         <= RESET_PC;
      res_q        <= 8'h00;
      zflag_q      <= 1'b0;
      alu_op_q     <= 4'h0;
      alu_in0_q    <= 8'h00;
      alu_in1_q    <= 8'h00;
      dmem_addr_q  <= 8'h00;
      dmem_wdata_q <= 8'h00;
      dmem_we_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: if (imem_ack) begin
          op_q      <= fetch_ins.op;
          rd_q      <= fetch_ins.rd;
          alu_op_q  <= fetch_ins.op;
          alu_in0_q <= in0_d;
          alu_in1_q <= in1_d;
        end
        StExec: begin
          res_q <= alu_out;
          if (sets_zf(op_q)) zflag_q <= alu_zf;
          if (is_mem_op) begin
            dmem_addr_q <= alu_out;
            dmem_we_q   <= (op_q == OpStore);
            if (op_q == OpStore) dmem_wdata_q <= rd_val;
          end
        end
        StMem: if (dmem_ack) begin
          if (op_q == OpLoad) res_q <= dmem_rdata;
          dmem_we_q <= 1'b0;
        end
        StWb:    pc_q <= next_pc;
        default: ;
      endcase
    end
  end

  // Requests are gated by rst_n so a reset cycle never shows a live request.
  assign imem_req   = rst_n && (state_q == StFetch);
  assign dmem_req   = rst_n && (state_q == StMem);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign alu_op     = alu_op_q;
  assign alu_in0    = alu_in0_q;
  assign alu_in1    = alu_in1_q;

`ifdef CPU_CTRL_ILLOP_HALT_EN
  assign halted = (state_q == StHalt);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
- Multi-cycle fetch/execute sequencer and instruction decoder for the 8-bit RISC-like CPU.
- It is the producer side of the ALU interface:
  - decodes 16-bit instructions;
  - drives alu_op/alu_in0/alu_in1;
  - consumes alu_out/alu_zf;
  - owns PC, the 4x8 register file and the zero flag;
  - runs req/ack handshakes to instruction and data memory.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- REG_INIT, 8'h00, reset value of r0..r3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  8  fetch address (equals pc).
- imem_ack  in  1  fetch complete this cycle.
- imem_rdata  in  16  instruction, valid when imem_ack=1.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  8  data address.
- dmem_wdata  out  8  store data.
- dmem_ack  in  1  data access complete this cycle.
- dmem_rdata  in  8  load data, valid when dmem_ack=1.
- alu_op  out  4  opcode to ALU.
- alu_in0  out  8  ALU operand 0.
- alu_in1  out  8  ALU operand 1.
- alu_out  in  8  ALU result (combinational from alu_*).
- alu_zf  in  1  ALU flag: 1 when alu_out != 0.
- pc  out  8  current program counter.
- halted  out  1  sticky illegal-op halt (see Optional Feature).

Behaviour:
- Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
- Opcode map (4-bit):
  - AND=0, OR=1, ADD=2, SUB=3, CMP=4, ADDI=5, SUBI=6, CMPI=7
  - LOAD=8, STORE=9, JMP=10, JMPR=11, JNZ=12, LI=13
  - 14 and 15 are illegal.
- Reset (rst_n=0 at an edge):
  - state=FETCH, pc=RESET_PC, r0..r3=REG_INIT, zflag=0, halted=0.
  - All req/we=0; alu_op/alu_in0/alu_in1/dmem_addr/dmem_wdata=0.
  - Reset mid-transfer abandons the access. An ack arriving later is ignored unless the FSM is in the matching state.
- FSM states: FETCH, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=1 with imem_addr=pc, held stable until an imem_ack cycle.
  - On ack: latch IR and register alu_op/alu_in0/alu_in1 from imem_rdata and the register file; go to EXEC.
  - imem_req drops the cycle after ack.
- Operand mapping:
  - AND/OR/ADD/SUB/CMP: in0=R[rs], in1=R[rd]. SUB yields R[rd]-R[rs].
  - ADDI/SUBI/CMPI: in0=imm, in1=R[rd].
  - LOAD/STORE/JMPR: in0=imm, in1=R[rs].
  - JMP/JNZ/LI: in0=imm, in1=0.
- EXEC (1 cycle):
  - Capture alu_out into res.
  - Ops 0-7 load zflag from alu_zf; all other ops leave zflag unchanged.
  - LOAD/STORE go to MEM with dmem_addr=alu_out; STORE sets dmem_wdata=R[rd] and dmem_we=1.
  - All other ops go to WB.
- MEM:
  - dmem_req=1 with addr/we/wdata stable until a dmem_ack cycle.
  - LOAD captures dmem_rdata into res. Go to WB.
- WB (1 cycle):
  - Register write: AND/OR/ADD/SUB/ADDI/SUBI/LI/LOAD write R[rd]=res. CMP/CMPI/STORE/jumps write nothing.
  - PC update: JMP pc=res; JMPR pc=res; JNZ pc = zflag ? res : pc+1; otherwise pc+1.
  - Return to FETCH.
- Arithmetic: all arithmetic is mod 256. pc 8'hFF+1 wraps to 8'h00; JMPR R[rs]+imm wraps.
- Latency: ALU op with zero-wait ack takes 3 cycles; LOAD/STORE with zero-wait acks take 4. Each wait cycle adds 1.
- An ack while req=0 is ignored.
- pc, alu_*, dmem_addr and dmem_wdata hold their values outside update points.

Optional Feature:
- Macro: CPU_CTRL_ILLOP_HALT_EN.
- Defined: opcode 14/15 at EXEC goes to HALT; halted=1; no req issued; pc frozen. Only reset exits HALT.
- Undefined: opcodes 14/15 execute as NOP (no reg/flag write, pc+1); halted tied to 0.

Decomposition:
- Shared package (def.h): 4-bit opcode constants, instruction field positions, FSM state encoding.
- The ALU stays external to this block.
- One natural sub-module: cpu_regfile (4x8; two asynchronous read ports, one synchronous write port, synchronous active-low reset).

Test Plan:
- Reset then LI r1,0x05 and LI r2,0x03, then SUB r1,r2 with zero-wait acks:
  - alu_op=3, alu_in0=0x03, alu_in1=0x05;
  - r1=0x02, zflag=1, pc=3;
  - 3 cycles per instruction.
- CMPI with r0=0x07, imm 0x07 then JNZ 0x40: alu_out=1 gives zflag=1, so pc=0x40. Repeat with imm 0x08: pc falls through to +1.
- STORE r3 -> [r1+0x10] with r1=0xF8, r3=0xAA, dmem_ack delayed 2 cycles:
  - dmem_req held 3 cycles;
  - dmem_addr=0x08 (wrap), dmem_we=1, dmem_wdata=0xAA stable throughout.
- pc=0xFF executing ADD: next fetch imem_addr=0x00. JMPR with R[rs]=0xF0, imm 0x20 gives pc=0x10.
- rst_n low during MEM wait with ack arriving the cycle after reset:
  - all outputs at reset values;
  - FETCH from RESET_PC;
  - stray dmem_ack causes no register change.
- Opcode 0xF: with CPU_CTRL_ILLOP_HALT_EN, halted=1 and no further imem_req; without it, r0..r3 unchanged and pc+1.
